sram_bus_arbiter: RTL and testbench
===================================

// Module: sram_bus_arbiter
// PURPOSE
//  Shares one SRAM-like memory port between the IF-stage instruction master and the
//  EX/MEM-stage data master. Sits between the pipeline stages and the memory bridge.
//  Data requests win over instruction requests. Per-request master IDs are queued so
//  each in-order data_ok/rdata beat returns to the master that issued it.
// PARAMETERS
//  OUTSTANDING  2  max accepted-but-unanswered transactions (1..4); sets ID FIFO depth
// PORTS
//  clk           in   1   core clock, all state on posedge
//  resetn        in   1   asynchronous active-low reset
//  inst_req      in   1   instruction request valid (always read)
//  inst_addr     in   32  instruction address
//  inst_addr_ok  out  1   instruction request accepted this cycle
//  inst_data_ok  out  1   instruction response valid this cycle
//  inst_rdata    out  32  instruction read data
//  data_req      in   1   data request valid
//  data_wr       in   1   1 = write, 0 = read
//  data_size     in   2   0 = byte, 1 = half, 2 = word
//  data_wstrb    in   4   byte write strobes
//  data_addr     in   32  data address
//  data_wdata    in   32  data write data
//  data_addr_ok  out  1   data request accepted this cycle
//  data_data_ok  out  1   data response valid this cycle (read data or write ack)
//  data_rdata    out  32  data read data
//  mem_req, mem_wr, mem_size[2], mem_wstrb[4], mem_addr[32], mem_wdata[32]  out  shared port request
//  mem_addr_ok   in   1   memory accepted mem_req
//  mem_data_ok   in   1   memory response beat (in request order)
//  mem_rdata     in   32  memory read data
//  arb_err       out  1   sticky: mem_data_ok seen with no outstanding transaction
// BEHAVIOUR
//  - Reset: FIFO empty, lock clear, arb_err=0; every output 0 while resetn=0.
//  - Accept: transfer when mem_req & mem_addr_ok. Same cycle, push the granted ID onto
//    the FIFO and assert addr_ok to the granted master only. Zero added latency.
//  - Grant, when unlocked: data if data_req, else inst if inst_req. mem_* mirrors the
//    granted master's fields combinationally. Inst grants drive wr=0, size=2, wstrb=0.
//  - Lock: if mem_req=1 and mem_addr_ok=0, register the grant. The grant holds on
//    following cycles until acceptance. The other master cannot preempt it, so the
//    request stays stable for the slave.
//  - Full: when FIFO count == OUTSTANDING, force mem_req=0 and both addr_ok=0.
//    The lock is kept.
//  - Response: mem_data_ok pops the FIFO head. Drive {head's}_data_ok=1 with
//    rdata=mem_rdata. The other master sees data_ok=0 and rdata=0.
//  - Simultaneous push and pop: count unchanged, pointers both advance. A full FIFO
//    with a pop in the same cycle still blocks the push that cycle, so there is no
//    combinational path from mem_data_ok to mem_req.
//  - Empty pop: mem_data_ok with count=0 sets arb_err and is otherwise dropped.
//    Pointers and count do not change.
//  - Pointers wrap modulo OUTSTANDING.
//  - Reset mid-operation: FIFO and lock clear immediately. Late slave beats after reset
//    set arb_err; flushing the slave is the memory bridge's job.
//  - Masters must hold req and fields stable until addr_ok. The arbiter does not check this.
// STRUCTURE
//  - Shared constants.h: `ARB_ID_INST=1'b0, `ARB_ID_DATA=1'b1, `MEM_SIZE_WORD=2'd2.
//  - Sub-module arb_id_fifo: 1-bit-wide, OUTSTANDING-deep, with push/pop/full/empty/head,
//    and asynchronous clear on resetn.
//  - Top level holds the grant mux, the lock register and response routing.
// TESTING
//  1. Only inst_req=1, addr=0x1c000000, mem_addr_ok=1 -> inst_addr_ok=1 the same cycle;
//     mem_data_ok with rdata=0x02800c0c -> inst_data_ok=1, inst_rdata=0x02800c0c.
//  2. inst_req and data_req both 1 (data read 0x00001000) -> mem_addr=0x00001000,
//     data_addr_ok=1, inst_addr_ok=0.
//  3. inst granted with mem_addr_ok=0 for 3 cycles; data_req rises in cycle 2 ->
//     mem_addr stays the inst address until accepted, then data wins.
//  4. OUTSTANDING=2: accept 2 requests with no data_ok -> mem_req=0 on cycle 3;
//     one data_ok -> mem_req=1 on the next cycle.
//  5. Accept inst, then data, then a same-cycle accept plus data_ok -> responses route
//     inst, data in order; FIFO count stays at 1.
//  6. mem_data_ok while empty -> arb_err=1 and stays set; resetn pulse low mid-transfer
//     -> all outputs 0, FIFO empty, arb_err=0.

Source files
------------

// File: rtl/sram_bus_arbiter_pkg.sv
// Shared IDs and constants for the instruction/data SRAM bus arbiter.
package sram_bus_arbiter_pkg;

  typedef logic arb_id_t;

  localparam arb_id_t    ARB_ID_INST   = 1'b0;
  localparam arb_id_t    ARB_ID_DATA   = 1'b1;
  localparam logic [1:0] MEM_SIZE_WORD = 2'd2;

endpackage

// File: rtl/sram_bus_arbiter_id_fifo.sv
// Small FIFO of master IDs, one entry per accepted-but-unanswered memory request.
module sram_bus_arbiter_id_fifo
  import sram_bus_arbiter_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic    clk,
  input  logic    resetn,
  input  logic    push,
  input  arb_id_t push_id,
  input  logic    pop,
  output logic    full,
  output logic    empty,
  output arb_id_t head
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  arb_id_t         mem_q [DEPTH];
  arb_id_t         mem_d [DEPTH];
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            do_push, do_pop;

  function automatic logic [PW-1:0] inc_ptr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign head    = mem_q[rd_ptr_q];
  // Push is judged against the registered count so a same-cycle pop never
  // frees room combinationally.
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = push_id;
      wr_ptr_d        = inc_ptr(wr_ptr_q);
    end
    if (do_pop) begin
      rd_ptr_d = inc_ptr(rd_ptr_q);
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= ARB_ID_INST;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/sram_bus_arbiter.sv
// Shares one SRAM-like port between instruction and data masters; data has
// priority, a stalled grant is locked, and responses are routed by a queued ID.
module sram_bus_arbiter
  import sram_bus_arbiter_pkg::*;
#(
  parameter int OUTSTANDING = 2
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        inst_req,
  input  logic [31:0] inst_addr,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  output logic [31:0] inst_rdata,
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [3:0]  data_wstrb,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,
  output logic        mem_req,
  output logic        mem_wr,
  output logic [1:0]  mem_size,
  output logic [3:0]  mem_wstrb,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_addr_ok,
  input  logic        mem_data_ok,
  input  logic [31:0] mem_rdata,
  output logic        arb_err
);

  logic    lock_q, lock_d;
  arb_id_t lock_id_q, lock_id_d;
  logic    err_q, err_d;
  logic    grant_valid;
  arb_id_t grant_id;
  logic    accept;
  logic    fifo_full, fifo_empty;
  arb_id_t fifo_head;
  logic    resp_valid;

  // A locked grant keeps its master even if the other one now requests.
  always_comb begin
    grant_valid = 1'b0;
    grant_id    = ARB_ID_INST;
    if (lock_q) begin
      grant_valid = 1'b1;
      grant_id    = lock_id_q;
    end else if (data_req) begin
      grant_valid = 1'b1;
      grant_id    = ARB_ID_DATA;
    end else if (inst_req) begin
      grant_valid = 1'b1;
      grant_id    = ARB_ID_INST;
    end
  end

  assign mem_req = resetn & grant_valid & ~fifo_full;
  assign accept  = mem_req & mem_addr_ok;

  always_comb begin
    mem_wr    = 1'b0;
    mem_size  = 2'd0;
    mem_wstrb = 4'd0;
    mem_addr  = 32'd0;
    mem_wdata = 32'd0;
    if (mem_req) begin
      if (grant_id == ARB_ID_DATA) begin
        mem_wr    = data_wr;
        mem_size  = data_size;
        mem_wstrb = data_wstrb;
        mem_addr  = data_addr;
        mem_wdata = data_wdata;
      end else begin
        mem_size  = MEM_SIZE_WORD;
        mem_addr  = inst_addr;
      end
    end
  end

  assign inst_addr_ok = accept & (grant_id == ARB_ID_INST);
  assign data_addr_ok = accept & (grant_id == ARB_ID_DATA);

  // Offered but not taken: pin the grant; a full-FIFO stall leaves it as is.
  always_comb begin
    lock_d    = lock_q;
    lock_id_d = lock_id_q;
    if (accept) begin
      lock_d = 1'b0;
    end else if (mem_req) begin
      lock_d    = 1'b1;
      lock_id_d = grant_id;
    end
  end

  assign resp_valid   = resetn & mem_data_ok & ~fifo_empty;
  assign inst_data_ok = resp_valid & (fifo_head == ARB_ID_INST);
  assign data_data_ok = resp_valid & (fifo_head == ARB_ID_DATA);
  assign inst_rdata   = inst_data_ok ? mem_rdata : 32'd0;
  assign data_rdata   = data_data_ok ? mem_rdata : 32'd0;

  assign err_d   = err_q | (mem_data_ok & fifo_empty);
  assign arb_err = err_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      lock_q    <= 1'b0;
      lock_id_q <= ARB_ID_INST;
      err_q     <= 1'b0;
    end else begin
      lock_q    <= lock_d;
      lock_id_q <= lock_id_d;
      err_q     <= err_d;
    end
  end

  sram_bus_arbiter_id_fifo #(
    .DEPTH (OUTSTANDING)
  ) u_id_fifo (
    .clk     (clk),
    .resetn  (resetn),
    .push    (accept),
    .push_id (grant_id),
    .pop     (mem_data_ok),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .head    (fifo_head)
  );

endmodule

// File: tb/tb_sram_bus_arbiter.sv
// Directed bench: stimulus drives masters and the memory side, a monitor
// checks every returned beat against a queue of expected responses.
module tb_sram_bus_arbiter;

  logic        clk = 1'b0;
  logic        resetn;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_addr_ok, inst_data_ok;
  logic [31:0] inst_rdata;
  logic        data_req, data_wr;
  logic [1:0]  data_size;
  logic [3:0]  data_wstrb;
  logic [31:0] data_addr, data_wdata;
  logic        data_addr_ok, data_data_ok;
  logic [31:0] data_rdata;
  logic        mem_req, mem_wr;
  logic [1:0]  mem_size;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_addr, mem_wdata;
  logic        mem_addr_ok, mem_data_ok;
  logic [31:0] mem_rdata;
  logic        arb_err;

  typedef struct packed {
    logic        is_data;
    logic [31:0] rdata;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  sram_bus_arbiter #(.OUTSTANDING(2)) dut (
    .clk          (clk),
    .resetn       (resetn),
    .inst_req     (inst_req),
    .inst_addr    (inst_addr),
    .inst_addr_ok (inst_addr_ok),
    .inst_data_ok (inst_data_ok),
    .inst_rdata   (inst_rdata),
    .data_req     (data_req),
    .data_wr      (data_wr),
    .data_size    (data_size),
    .data_wstrb   (data_wstrb),
    .data_addr    (data_addr),
    .data_wdata   (data_wdata),
    .data_addr_ok (data_addr_ok),
    .data_data_ok (data_data_ok),
    .data_rdata   (data_rdata),
    .mem_req      (mem_req),
    .mem_wr       (mem_wr),
    .mem_size     (mem_size),
    .mem_wstrb    (mem_wstrb),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_addr_ok  (mem_addr_ok),
    .mem_data_ok  (mem_data_ok),
    .mem_rdata    (mem_rdata),
    .arb_err      (arb_err)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end else begin
      $display("ok   %s: 0x%08h at %0t", name, act, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_resp(input logic is_data, input logic [31:0] rdata);
    exp_t e;
    e.is_data = is_data;
    e.rdata   = rdata;
    exp_q.push_back(e);
  endtask

  // Response monitor: one queue entry per returned beat, in order.
  always @(negedge clk) begin
    if (resetn && (inst_data_ok || data_data_ok)) begin
      if (inst_data_ok && data_data_ok) begin
        chk("resp_both_masters", 32'd1, 32'd0);
      end else if (exp_q.size() == 0) begin
        chk("resp_unexpected", {31'd0, data_data_ok}, 32'hffff_ffff);
      end else begin
        mon_e = exp_q.pop_front();
        chk("resp_master_is_data", {31'd0, data_data_ok}, {31'd0, mon_e.is_data});
        chk("resp_rdata", data_data_ok ? data_rdata : inst_rdata, mon_e.rdata);
        chk("resp_other_rdata", data_data_ok ? inst_rdata : data_rdata, 32'd0);
      end
    end
  end

  initial begin
    resetn      = 1'b0;
    inst_req    = 1'b1;
    inst_addr   = 32'h1c00_0000;
    data_req    = 1'b0;
    data_wr     = 1'b0;
    data_size   = 2'd0;
    data_wstrb  = 4'd0;
    data_addr   = 32'd0;
    data_wdata  = 32'd0;
    mem_addr_ok = 1'b1;
    mem_data_ok = 1'b1;
    mem_rdata   = 32'h1234_5678;

    // Reset held with active inputs: every output must be quiet.
    @(negedge clk);
    chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
    chk("rst_inst_addr_ok", {31'd0, inst_addr_ok}, 32'd0);
    chk("rst_inst_data_ok", {31'd0, inst_data_ok}, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_arb_err", {31'd0, arb_err}, 32'd0);

    tick();
    resetn = 1'b1; inst_req = 1'b0; mem_addr_ok = 1'b0; mem_data_ok = 1'b0;
    @(negedge clk);
    chk("idle_mem_req", {31'd0, mem_req}, 32'd0);

    // 1: lone instruction fetch, zero-latency accept, then its beat.
    tick();
    inst_req = 1'b1; inst_addr = 32'h1c00_0000; mem_addr_ok = 1'b1;
    @(negedge clk);
    chk("t1_inst_addr_ok", {31'd0, inst_addr_ok}, 32'd1);
    chk("t1_mem_addr", mem_addr, 32'h1c00_0000);
    chk("t1_mem_size", {30'd0, mem_size}, 32'd2);
    chk("t1_mem_wr", {31'd0, mem_wr}, 32'd0);
    tick();
    inst_req = 1'b0; mem_addr_ok = 1'b0;
    mem_data_ok = 1'b1; mem_rdata = 32'h0280_0c0c; expect_resp(1'b0, 32'h0280_0c0c);
    @(negedge clk);
    tick();
    mem_data_ok = 1'b0;

    // 2: both request, data wins; inst follows next cycle.
    tick();
    inst_req = 1'b1; inst_addr = 32'h1c00_0004;
    data_req = 1'b1; data_wr = 1'b0; data_size = 2'd0; data_addr = 32'h0000_1000;
    mem_addr_ok = 1'b1;
    @(negedge clk);
    chk("t2_mem_addr", mem_addr, 32'h0000_1000);
    chk("t2_data_addr_ok", {31'd0, data_addr_ok}, 32'd1);
    chk("t2_inst_addr_ok", {31'd0, inst_addr_ok}, 32'd0);
    chk("t2_mem_size", {30'd0, mem_size}, 32'd0);
    tick();
    data_req = 1'b0;
    @(negedge clk);
    chk("t2_inst_follow_addr_ok", {31'd0, inst_addr_ok}, 32'd1);
    chk("t2_inst_follow_addr", mem_addr, 32'h1c00_0004);
    tick();
    inst_req = 1'b0; mem_addr_ok = 1'b0;
    mem_data_ok = 1'b1; mem_rdata = 32'haaaa_0001; expect_resp(1'b1, 32'haaaa_0001);
    tick();
    mem_rdata = 32'hbbbb_0002; expect_resp(1'b0, 32'hbbbb_0002);
    tick();
    mem_data_ok = 1'b0;

    // 3: stalled instruction grant is locked against a later data request.
    tick();
    inst_req = 1'b1; inst_addr = 32'h1c00_0100; mem_addr_ok = 1'b0;
    @(negedge clk);
    chk("t3_c1_mem_addr", mem_addr, 32'h1c00_0100);
    chk("t3_c1_inst_addr_ok", {31'd0, inst_addr_ok}, 32'd0);
    tick();
    data_req = 1'b1; data_wr = 1'b1; data_size = 2'd2; data_wstrb = 4'hf;
    data_addr = 32'h0000_2000; data_wdata = 32'h1234_5678;
    @(negedge clk);
    chk("t3_c2_mem_addr", mem_addr, 32'h1c00_0100);
    chk("t3_c2_mem_wr", {31'd0, mem_wr}, 32'd0);
    chk("t3_c2_data_addr_ok", {31'd0, data_addr_ok}, 32'd0);
    tick();
    @(negedge clk);
    chk("t3_c3_mem_addr", mem_addr, 32'h1c00_0100);
    tick();
    mem_addr_ok = 1'b1;
    @(negedge clk);
    chk("t3_c4_inst_addr_ok", {31'd0, inst_addr_ok}, 32'd1);
    chk("t3_c4_data_addr_ok", {31'd0, data_addr_ok}, 32'd0);
    chk("t3_c4_mem_addr", mem_addr, 32'h1c00_0100);
    tick();
    inst_req = 1'b0;
    @(negedge clk);
    chk("t3_c5_mem_addr", mem_addr, 32'h0000_2000);
    chk("t3_c5_mem_wr", {31'd0, mem_wr}, 32'd1);
    chk("t3_c5_mem_wstrb", {28'd0, mem_wstrb}, 32'hf);
    chk("t3_c5_mem_wdata", mem_wdata, 32'h1234_5678);
    chk("t3_c5_data_addr_ok", {31'd0, data_addr_ok}, 32'd1);

    // 4: two outstanding -> full; a pop in the same cycle still blocks.
    tick();
    data_req = 1'b0; inst_req = 1'b1; inst_addr = 32'h1c00_0200;
    @(negedge clk);
    chk("t4_full_mem_req", {31'd0, mem_req}, 32'd0);
    chk("t4_full_inst_addr_ok", {31'd0, inst_addr_ok}, 32'd0);
    tick();
    mem_data_ok = 1'b1; mem_rdata = 32'h1111_0000; expect_resp(1'b0, 32'h1111_0000);
    @(negedge clk);
    chk("t4_full_pop_mem_req", {31'd0, mem_req}, 32'd0);
    tick();
    mem_data_ok = 1'b0;
    @(negedge clk);
    chk("t4_after_pop_mem_req", {31'd0, mem_req}, 32'd1);
    chk("t4_after_pop_inst_addr_ok", {31'd0, inst_addr_ok}, 32'd1);
    chk("t4_after_pop_mem_addr", mem_addr, 32'h1c00_0200);

    // 5: drain the data write ack, then a same-cycle accept plus pop.
    tick();
    inst_req = 1'b0; mem_addr_ok = 1'b0;
    mem_data_ok = 1'b1; mem_rdata = 32'h2222_0000; expect_resp(1'b1, 32'h2222_0000);
    tick();
    data_req = 1'b1; data_wr = 1'b0; data_wstrb = 4'd0; data_addr = 32'h0000_3000;
    mem_addr_ok = 1'b1;
    mem_rdata = 32'h3333_0000; expect_resp(1'b0, 32'h3333_0000);
    @(negedge clk);
    chk("t5_data_addr_ok", {31'd0, data_addr_ok}, 32'd1);
    chk("t5_mem_addr", mem_addr, 32'h0000_3000);
    tick();
    data_req = 1'b0; mem_addr_ok = 1'b0;
    mem_rdata = 32'h4444_0000; expect_resp(1'b1, 32'h4444_0000);

    // 6: beat with nothing outstanding is dropped and flags a sticky error.
    tick();
    mem_rdata = 32'hdead_beef;
    @(negedge clk);
    chk("t6_empty_inst_data_ok", {31'd0, inst_data_ok}, 32'd0);
    chk("t6_empty_data_data_ok", {31'd0, data_data_ok}, 32'd0);
    chk("t6_err_not_yet", {31'd0, arb_err}, 32'd0);
    tick();
    mem_data_ok = 1'b0;
    @(negedge clk);
    chk("t6_arb_err_set", {31'd0, arb_err}, 32'd1);
    tick();
    @(negedge clk);
    chk("t6_arb_err_sticky", {31'd0, arb_err}, 32'd1);

    // Reset pulse while an instruction grant is locked.
    tick();
    inst_req = 1'b1; inst_addr = 32'h1c00_0300; mem_addr_ok = 1'b0;
    @(negedge clk);
    chk("t6_lock_mem_req", {31'd0, mem_req}, 32'd1);
    tick();
    resetn = 1'b0;
    #1;
    chk("t6_rst_mem_req", {31'd0, mem_req}, 32'd0);
    chk("t6_rst_mem_addr", mem_addr, 32'd0);
    chk("t6_rst_arb_err", {31'd0, arb_err}, 32'd0);
    tick();
    resetn = 1'b1; inst_req = 1'b0;
    data_req = 1'b1; data_wr = 1'b0; data_size = 2'd2; data_addr = 32'h0000_4000;
    mem_addr_ok = 1'b1;
    @(negedge clk);
    chk("t6_post_rst_mem_addr", mem_addr, 32'h0000_4000);
    chk("t6_post_rst_data_addr_ok", {31'd0, data_addr_ok}, 32'd1);
    chk("t6_post_rst_inst_addr_ok", {31'd0, inst_addr_ok}, 32'd0);
    tick();
    data_req = 1'b0; mem_addr_ok = 1'b0;
    mem_data_ok = 1'b1; mem_rdata = 32'h5555_0000; expect_resp(1'b1, 32'h5555_0000);
    tick();
    mem_data_ok = 1'b0;
    @(negedge clk);
    chk("t6_post_rst_arb_err", {31'd0, arb_err}, 32'd0);
    chk("scoreboard_drained", exp_q.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
